// File: rtl/exe_pkg.sv
// Shared definitions for the execution stage: ALU command codes,
// multiplier FSM state encoding and the default datapath width.
package exe_pkg;

    localparam int EXE_WIDTH = 32;

    localparam logic [4:0] CMD_ADD = 5'b00000;
    localparam logic [4:0] CMD_SUB = 5'b00010;
    localparam logic [4:0] CMD_AND = 5'b00100;
    localparam logic [4:0] CMD_OR  = 5'b00101;
    localparam logic [4:0] CMD_NOR = 5'b00110;
    localparam logic [4:0] CMD_XOR = 5'b00111;
    localparam logic [4:0] CMD_SLL = 5'b01000;
    localparam logic [4:0] CMD_SRA = 5'b01001;
    localparam logic [4:0] CMD_SRL = 5'b01010;
    localparam logic [4:0] CMD_MUL = 5'b01100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } exe_state_t;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE input bundle, EX/MEM output bundle and the stall/branch
// feedback signals of the execution stage.
interface exe_stage_if import exe_pkg::*; #(
    parameter int WIDTH = EXE_WIDTH
);
    // ID/EXE bundle
    logic [WIDTH-1:0] pc_in;
    logic [4:0]       dest_in;
    logic [WIDTH-1:0] reg2_in;
    logic [WIDTH-1:0] val1_in;
    logic [WIDTH-1:0] val2_in;
    logic [4:0]       exe_cmd_in;
    logic             br_taken_in;
    logic             mem_r_en_in;
    logic             mem_w_en_in;
    logic             wb_en_in;

    // Feedback to fetch/decode
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_addr;

    // EX/MEM bundle
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] st_val;
    logic [4:0]       dest;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;

    // Upstream side: drives the ID/EXE bundle, observes the results.
    modport master (
        output pc_in, dest_in, reg2_in, val1_in, val2_in, exe_cmd_in,
               br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        input  stall, br_taken, br_addr,
               alu_result, st_val, dest, mem_r_en, mem_w_en, wb_en
    );

    // Execution stage side.
    modport slave (
        input  pc_in, dest_in, reg2_in, val1_in, val2_in, exe_cmd_in,
               br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in,
        output stall, br_taken, br_addr,
               alu_result, st_val, dest, mem_r_en, mem_w_en, wb_en
    );

endinterface

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier. A start pulse captures the operands;
// each following cycle consumes MUL_STEP multiplier bits. done_o is high
// in the last iteration cycle and product holds the low WIDTH bits of the
// unsigned product from the cycle after done_o until the next start.
module exe_mul_seq import exe_pkg::*; #(
    parameter int WIDTH    = EXE_WIDTH,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_o,
    output logic [WIDTH-1:0] product
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    generate
        if ((WIDTH % MUL_STEP) != 0) begin : g_bad_step
            $error("exe_mul_seq: MUL_STEP must divide WIDTH");
        end
    endgenerate

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplr_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] step_sum;

    // Partial sum for this iteration: add the shifted multiplicand for
    // every set bit among the low MUL_STEP multiplier bits.
    always_comb begin
        step_sum = acc_p0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplr_p0[j]) begin
                step_sum = step_sum + (mcand_p0 << j);
            end
        end
    end

    // Operand capture on start, then one MUL_STEP-bit iteration per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            mcand_p0 <= '0;
            mplr_p0  <= '0;
            acc_p0   <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            mcand_p0 <= a;
            mplr_p0  <= b;
            acc_p0   <= '0;
        end else if (busy) begin
            acc_p0   <= step_sum;
            mcand_p0 <= mcand_p0 << MUL_STEP;
            mplr_p0  <= mplr_p0 >> MUL_STEP;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
                busy <= 1'b0;
            end
        end
    end

    assign done_o  = busy && (cnt == LAST_CNT);
    assign product = acc_p0;

endmodule

// File: rtl/exe_stage.sv
// Execution stage: single-cycle ALU, iterative multiplier with upstream
// stall, combinational branch target and the EX/MEM pipeline register.
module exe_stage import exe_pkg::*; #(
    parameter int WIDTH    = EXE_WIDTH,
    parameter int MUL_STEP = 1
) (
    input logic       clk,
    input logic       rst,
    exe_stage_if.slave bus
);

    exe_state_t       state_p0;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic             stall;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_out;

    logic [WIDTH-1:0] alu_result_p1;
    logic [WIDTH-1:0] st_val_p1;
    logic [4:0]       dest_p1;
    logic             mem_r_en_p1;
    logic             mem_w_en_p1;
    logic             wb_en_p1;

    // Single-cycle ALU; unknown codes (and MUL, which never reaches the
    // EX/MEM register through this path) behave as ADD.
    function automatic logic [WIDTH-1:0] alu_op(
        input logic [4:0]       cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        a_s = a;
        case (cmd)
            CMD_SUB: alu_op = a - b;
            CMD_AND: alu_op = a & b;
            CMD_OR:  alu_op = a | b;
            CMD_NOR: alu_op = ~(a | b);
            CMD_XOR: alu_op = a ^ b;
            CMD_SLL: alu_op = a << b[4:0];
            CMD_SRA: alu_op = $unsigned(a_s >>> b[4:0]);
            CMD_SRL: alu_op = a >> b[4:0];
            default: alu_op = a + b;
        endcase
    endfunction

    assign is_mul    = (bus.exe_cmd_in == CMD_MUL);
    assign mul_start = (state_p0 == ST_IDLE) && is_mul;
    // Stall is held low while reset is asserted even if a MUL sits on the inputs.
    assign stall     = !rst && (mul_start || (state_p0 == ST_RUN));
    assign alu_out   = alu_op(bus.exe_cmd_in, bus.val1_in, bus.val2_in);

    assign bus.stall    = stall;
    assign bus.br_taken = bus.br_taken_in;
    assign bus.br_addr  = bus.pc_in + (bus.val2_in << 2);

    exe_mul_seq #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.val1_in),
        .b       (bus.val2_in),
        .done_o  (mul_done),
        .product (mul_product)
    );

    // MUL sequencing: start once from IDLE, iterate in RUN, retire in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
        end else begin
            case (state_p0)
                ST_IDLE: if (is_mul) state_p0 <= ST_RUN;
                ST_RUN:  if (mul_done) state_p0 <= ST_DONE;
                ST_DONE: state_p0 <= ST_IDLE;
                default: state_p0 <= ST_IDLE;
            endcase
        end
    end

    // ---- EX/MEM boundary: bubble while stalled, product in DONE, else ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_p1 <= '0;
            st_val_p1     <= '0;
            dest_p1       <= '0;
            mem_r_en_p1   <= 1'b0;
            mem_w_en_p1   <= 1'b0;
            wb_en_p1      <= 1'b0;
        end else if (stall) begin
            alu_result_p1 <= '0;
            st_val_p1     <= '0;
            dest_p1       <= '0;
            mem_r_en_p1   <= 1'b0;
            mem_w_en_p1   <= 1'b0;
            wb_en_p1      <= 1'b0;
        end else begin
            alu_result_p1 <= (state_p0 == ST_DONE) ? mul_product : alu_out;
            st_val_p1     <= bus.reg2_in;
            dest_p1       <= bus.dest_in;
            mem_r_en_p1   <= bus.mem_r_en_in;
            mem_w_en_p1   <= bus.mem_w_en_in;
            wb_en_p1      <= bus.wb_en_in;
        end
    end

    assign bus.alu_result = alu_result_p1;
    assign bus.st_val     = st_val_p1;
    assign bus.dest       = dest_p1;
    assign bus.mem_r_en   = mem_r_en_p1;
    assign bus.mem_w_en   = mem_w_en_p1;
    assign bus.wb_en      = wb_en_p1;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execution stage of the 5-stage pipeline. It consumes the ID/EXE register bundle (PC, Dest, Reg2, Val1, Val2, EXE_CMD, Br_taken, MEM_R_EN, MEM_W_EN, WB_EN) and produces the EX/MEM register bundle.
- Single-cycle ALU for logic, arithmetic and shift ops.
- Iterative shift-add multiplier for MUL; it holds the upstream pipeline with `stall` until the product is ready.
- Branch target is computed combinationally for the fetch stage.

Parameters:
- WIDTH, 32, datapath width.
- MUL_STEP, 1, multiplier bits consumed per cycle; must divide WIDTH (legal values 1, 2, 4).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_in  in  WIDTH  PC of the instruction in EXE
- dest_in  in  5  destination register
- reg2_in  in  WIDTH  store data
- val1_in  in  WIDTH  operand A
- val2_in  in  WIDTH  operand B / sign-extended immediate / shift amount
- exe_cmd_in  in  5  ALU command
- br_taken_in  in  1  branch decision from ID
- mem_r_en_in  in  1  load enable
- mem_w_en_in  in  1  store enable
- wb_en_in  in  1  writeback enable
- stall  out  1  combinational; freezes PC, IF/ID and ID/EXE registers
- br_taken  out  1  combinational, equals br_taken_in
- br_addr  out  WIDTH  combinational, pc_in + (val2_in << 2), mod 2^WIDTH
- alu_result  out  WIDTH  registered EX/MEM result
- st_val  out  WIDTH  registered reg2_in
- dest  out  5  registered
- mem_r_en  out  1  registered
- mem_w_en  out  1  registered
- wb_en  out  1  registered

Behaviour:
- EXE_CMD encoding (result arithmetic is mod 2^WIDTH, no overflow flag):
  - ADD 00000, SUB 00010, AND 00100, OR 00101, NOR 00110, XOR 00111.
  - SLL 01000, SRA 01001, SRL 01010; shift amount is val2_in[4:0].
  - MUL 01100 gives the low WIDTH bits of the unsigned product.
  - Any other code behaves as ADD.
- A bubble from ID/EXE is all-zero, i.e. ADD with all enables 0, and passes through unchanged.
- Reset: all registered outputs 0, FSM IDLE, counter 0, accumulator 0, stall 0. Applies immediately, including mid-multiply; the partial product is discarded.
- Non-MUL ops: latency 1. The EX/MEM outputs load the result and control bits at the next rising edge. stall = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: if exe_cmd_in == MUL, stall = 1; capture val1_in and val2_in, clear accumulator and counter, go to RUN. Otherwise stall = 0.
  - RUN: stall = 1. Each cycle processes MUL_STEP multiplier bits (add shifted multiplicand when the bit is set) and increments the counter. When counter == WIDTH/MUL_STEP − 1, go to DONE.
  - DONE: stall = 0. EX/MEM loads the product plus dest_in, wb_en_in, mem enables and reg2_in (held stable by the stalled upstream). Go to IDLE.
- MUL occupancy in EXE: 2 + WIDTH/MUL_STEP cycles (34 at defaults). stall is high for 1 + WIDTH/MUL_STEP of them (33).
- The IDLE-to-RUN decision is made once per instruction. In DONE the same MUL is still on the inputs and must not restart.
- Back-to-back MULs: the second MUL is seen in IDLE on the cycle after DONE and starts normally.
- While stall = 1, the EX/MEM register loads a bubble: all outputs 0. The MEM stage therefore never sees a half-finished MUL.
- Multiplier operands are sampled only on the IDLE-to-RUN transition. Input changes during RUN are ignored.
- br_taken and br_addr stay purely combinational from the inputs and are unaffected by the FSM. MUL never carries br_taken = 1.

Decomposition:
- Shared package exe_pkg holds:
  - EXE_CMD localparams (ADD … MUL);
  - FSM state encoding (IDLE, RUN, DONE);
  - WIDTH default.
- One sub-module, exe_mul_seq, contains the iterative multiplier. Ports: clk, rst, start, a, b, done_o (high in the final RUN cycle), product. exe_stage owns the FSM, ALU mux and EX/MEM register.

Test Plan:
- ADD: val1 = 0xFFFFFFFF, val2 = 1, wb_en = 1, dest = 5 → next edge alu_result = 0, dest = 5, wb_en = 1, stall never high.
- SRA and SUB in back-to-back cycles:
  - SRA with val1 = 0x80000000, val2 = 4 → alu_result = 0xF8000000.
  - SUB with val1 = 3, val2 = 5 → alu_result = 0xFFFFFFFE.
  - Each result appears exactly 1 cycle after its input.
- MUL 7 × 6, dest = 9:
  - stall high exactly 33 consecutive cycles;
  - EX/MEM shows bubbles (wb_en = 0) during the stall;
  - the edge after stall drops gives alu_result = 42, dest = 9, wb_en = 1.
- MUL 0xFFFFFFFF × 2 immediately followed by MUL 0x10000 × 0x10000 → results 0xFFFFFFFE then 0x00000000; each stalls 33 cycles; no missed or duplicate start.
- Assert rst for 1 cycle at stall cycle 10 of a MUL → outputs 0 and stall 0 immediately. A following ADD 1 + 1 completes with result 2 in 1 cycle.
- Branch: pc_in = 0x100, val2 = 0xFFFFFFFE, br_taken_in = 1 → br_addr = 0xF8 and br_taken = 1 in the same cycle.
